// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage, one result bit per cycle.
// Multiply: full 2W-bit product. Divide: {remainder, quotient}, restoring.
// Optional build macro MULDIV_EARLY_OUT_EN: multiply leaves CALC once the
// remaining multiplier magnitude is zero (at least one CALC cycle).
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           annul_i,
    input  logic           op_i,
    input  logic           signed_i,
    input  logic [W-1:0]   opdata1_i,
    input  logic [W-1:0]   opdata2_i,
    output logic           busy_o,
    output logic           ready_o,
    output logic [2*W-1:0] result_o,
    output logic           div_by_zero_o
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, next_state;

    logic           op_q, sgn_q, s1_q, s2_q, dz_q;
    logic [CW-1:0]  cnt;
    logic [2*W:0]   acc;      // mul: product accumulator; div: {remainder, quotient}
    logic [2*W-1:0] mcand;    // shifted multiplicand
    logic [W-1:0]   mplier;   // multiplier (shifts right) or divisor (static)

    logic [W-1:0]   mag1, mag2;
    logic           accept, calc_last;
    logic [2*W:0]   shifted, div_next;
    logic [W:0]     diff;
    logic [W-1:0]   quo, rem;
    logic [2*W-1:0] fixed_res;

    assign busy_o = (state != IDLE);
    assign accept = start_i && !annul_i;
    assign mag1   = (signed_i && opdata1_i[W-1]) ? -opdata1_i : opdata1_i;
    assign mag2   = (signed_i && opdata2_i[W-1]) ? -opdata2_i : opdata2_i;

`ifdef MULDIV_EARLY_OUT_EN
    assign calc_last = (cnt == LAST) || (!op_q && (mplier[W-1:1] == '0));
`else
    assign calc_last = (cnt == LAST);
`endif

    // Restoring divide step: shift in next dividend bit, subtract if it fits.
    // diff[W] set means the trial subtraction went negative.
    always_comb begin
        shifted  = acc << 1;
        diff     = shifted[2*W:W] - {1'b0, mplier};
        div_next = diff[W] ? shifted : {diff, shifted[W-1:1], 1'b1};
    end

    // Sign correction and divide-by-zero substitution applied in FIX.
    always_comb begin
        quo = acc[W-1:0];
        rem = acc[2*W-1:W];
        fixed_res = acc[2*W-1:0];
        if (dz_q) begin
            fixed_res = {acc[2*W-1:W], {W{1'b1}}};
        end else if (!op_q) begin
            if (sgn_q && (s1_q ^ s2_q)) fixed_res = -acc[2*W-1:0];
        end else begin
            if (sgn_q && (s1_q ^ s2_q)) quo = -quo;
            if (sgn_q && s1_q)          rem = -rem;
            fixed_res = {rem, quo};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; annul returns to IDLE ahead of completion.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (op_i && opdata2_i == '0) ? FIX : CALC;
            CALC: begin
                if (annul_i)        next_state = IDLE;
                else if (calc_last) next_state = FIX;
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= 1'b0;
            sgn_q         <= 1'b0;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            dz_q          <= 1'b0;
            cnt           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            ready_o       <= 1'b0;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_i;
                        sgn_q  <= signed_i;
                        s1_q   <= opdata1_i[W-1];
                        s2_q   <= opdata2_i[W-1];
                        dz_q   <= op_i && (opdata2_i == '0);
                        cnt    <= '0;
                        mplier <= mag2;
                        if (op_i) begin
                            mcand <= '0;
                            // Divide by zero parks the raw dividend in the remainder half.
                            if (opdata2_i == '0) acc <= {1'b0, opdata1_i, {W{1'b0}}};
                            else                 acc <= {{(W+1){1'b0}}, mag1};
                        end else begin
                            mcand <= {{W{1'b0}}, mag1};
                            acc   <= '0;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (op_q) begin
                        acc <= div_next;
                    end else begin
                        if (mplier[0]) acc <= acc + {1'b0, mcand};
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: begin
                    if (!annul_i) begin
                        ready_o       <= 1'b1;
                        result_o      <= fixed_res;
                        div_by_zero_o <= dz_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomised self-checking bench for muldiv_iter (W=32) against an
// arithmetic reference model; covers latency, handshake, annul and reset.
module tb_muldiv_iter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst, start_i, annul_i, op_i, signed_i;
    logic [W-1:0]   opdata1_i, opdata2_i;
    logic           busy_o, ready_o, div_by_zero_o;
    logic [2*W-1:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_res = '0;

    muldiv_iter #(.W(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .op_i(op_i), .signed_i(signed_i), .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i), .busy_o(busy_o), .ready_o(ready_o),
        .result_o(result_o), .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: {div_by_zero, result} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input bit op, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p, q64, r64;
        if (!op) begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q64 = sa / sb;
            r64 = sa % sb;
        end else begin
            q64 = {32'd0, a / b};
            r64 = {32'd0, a % b};
        end
        return {1'b0, r64[31:0], q64[31:0]};
    endfunction

    // Edges from acceptance (E0) until ready_o is visible.
    function automatic int exp_lat(input bit op, input bit sgn, input logic [31:0] b);
        logic [31:0] m;
        int k;
        if (op && b == 32'd0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op) begin
            m = (sgn && b[31]) ? -b : b;
            k = 1;
            while ((m >> k) != 32'd0) k++;
            return k + 1;
        end
`else
        m = '0;
        k = int'(sgn) + int'(m);
`endif
        return W + 1;
    endfunction

    function automatic logic [31:0] pick;
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic garble;
        start_i   = 1'($urandom_range(0, 1));
        op_i      = 1'($urandom_range(0, 1));
        signed_i  = 1'($urandom_range(0, 1));
        opdata1_i = 32'($urandom);
        opdata2_i = 32'($urandom);
    endtask

    // Issue one op, scramble inputs while busy, return in the ready cycle.
    task automatic run_op(input bit op, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] m;
        int lat, n;
        bit seen;
        m   = model(op, sgn, a, b);
        lat = exp_lat(op, sgn, b);
        start_i = 1'b1; annul_i = 1'b0; op_i = op; signed_i = sgn;
        opdata1_i = a; opdata2_i = b;
        tick;
        check("busy_after_e0", 64'(busy_o), 64'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            garble;
            tick;
            n++;
            if (ready_o) seen = 1'b1;
            else check("busy_wait", 64'(busy_o), 64'd1);
        end
        start_i = 1'b0;
        check("latency", 64'(n), 64'(lat));
        check("busy_at_ready", 64'(busy_o), 64'd0);
        check("result", result_o, m[63:0]);
        check("div_by_zero", 64'(div_by_zero_o), 64'(m[64]));
        last_res = m[63:0];
    endtask

    task automatic after_ready;
        tick;
        check("ready_pulse", 64'(ready_o), 64'd0);
        check("not_queued", 64'(busy_o), 64'd0);
        check("result_hold", result_o, last_res);
    endtask

    task automatic quiet_window(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (ready_o) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 1'b0; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) tick;
        rst = 1'b0;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_dz", 64'(div_by_zero_o), 64'd0);
        tick;

        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_ff_const", result_o, 64'hFFFF_FFFE_0000_0001);
        after_ready;
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
        check("mul_m3x7_const", result_o, 64'hFFFF_FFFF_FFFF_FFEB);
        after_ready;
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_m7_2_const", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
        after_ready;
        run_op(1'b1, 1'b0, 32'd100, 32'd7);
        check("div_100_7_const", result_o, 64'h0000_0002_0000_000E);
        after_ready;
        run_op(1'b1, 1'b0, 32'd100, 32'd0);
        check("div_zero_const", result_o, 64'h0000_0064_FFFF_FFFF);
        after_ready;
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", result_o, 64'h0000_0000_8000_0000);
        after_ready;
        run_op(1'b0, 1'b0, 32'd5, 32'd0);
        // back-to-back: next issue driven in the ready cycle
        run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd0);
        run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7);
        after_ready;

        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());
            if ($urandom_range(0, 1) == 0) after_ready;
        end
        after_ready;

        // annul mid-divide
        start_i = 1'b1; op_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd5;
        tick;
        start_i = 1'b0;
        repeat (9) tick;
        annul_i = 1'b1;
        tick;
        annul_i = 1'b0;
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_ready", 64'(ready_o), 64'd0);
        quiet_window("annul_no_ready");
        check("annul_result", result_o, last_res);

        // reset mid-multiply
        start_i = 1'b1; op_i = 1'b0; signed_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'hFFFF_0000;
        tick;
        start_i = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        check("midrst_dz", 64'(div_by_zero_o), 64'd0);
        quiet_window("midrst_no_ready");

        run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        after_ready;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
